// File: rtl/framebuffer_stream_framer.sv
// framebuffer_stream_framer
//   Re-frames an RGB565 pixel stream arriving in subparts (s_axis_tlast marks
//   the end of each subpart) into a line-oriented stream. On the output,
//   m_axis_tlast marks the end of each line and m_axis_tuser marks the first
//   beat of each frame. A 2-entry skid buffer decouples the two sides, so
//   s_axis_tready is registered and has no combinational path from
//   m_axis_tready. Framing errors are reported as sticky flags.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : run request (STOPPED/RUNNING/STOPPING control)
//   clearErrors       : clears errLastEarly / errLastMissing
//   s_axis_*          : input stream (tlast = end of subpart)
//   m_axis_*          : output stream (tlast = end of line, tuser = frame start)
//   frameDone         : one-cycle pulse together with the last beat of a frame
//   errLastEarly      : sticky, s_axis_tlast seen before the expected subpart end
//   errLastMissing    : sticky, expected subpart end reached without s_axis_tlast
//   running           : 1 in RUNNING and STOPPING
module framebuffer_stream_framer #(
   parameter int X_RESOLUTION      = 128,
   parameter int Y_RESOLUTION      = 128,
   parameter int Y_LINE_RESOLUTION = 128,
   parameter int STREAM_WIDTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    clearErrors,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   output logic [STREAM_WIDTH-1:0] m_axis_tdata,
   output logic                    frameDone,
   output logic                    errLastEarly,
   output logic                    errLastMissing,
   output logic                    running
);

   localparam int BPL    = X_RESOLUTION * 16 / STREAM_WIDTH;
   localparam int NPARTS = Y_RESOLUTION / Y_LINE_RESOLUTION;
   localparam int BX_W   = (BPL > 1) ? $clog2(BPL) : 1;
   localparam int LY_W   = (Y_LINE_RESOLUTION > 1) ? $clog2(Y_LINE_RESOLUTION) : 1;
   localparam int PT_W   = (NPARTS > 1) ? $clog2(NPARTS) : 1;
   // buffer entry layout: {tuser, tlast, tdata}
   localparam int EW     = STREAM_WIDTH + 2;

   typedef enum logic [1:0] {
      STOPPED  = 2'd0,
      RUNNING  = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [BX_W-1:0]   beat_x_q, beat_x_d;
   logic [LY_W-1:0]   line_y_q, line_y_d;
   logic [PT_W-1:0]   part_q, part_d;
   logic [EW-1:0]     ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              tvalid_q, tready_q, frame_done_q;
   logic              err_early_q, err_early_d, err_missing_q, err_missing_d;
   logic              running_q;

   logic              acc_s, pop_s, eol_s, eop_s, last_part_s, first_s;
   logic              early_s, missing_s, frame_end_s;
   logic [EW-1:0]     in_entry_s;

   assign acc_s       = s_axis_tvalid & tready_q;
   assign pop_s       = tvalid_q & m_axis_tready;
   assign eol_s       = (beat_x_q == BX_W'(BPL - 1));
   assign eop_s       = eol_s && (line_y_q == LY_W'(Y_LINE_RESOLUTION - 1));
   assign last_part_s = (part_q == PT_W'(NPARTS - 1));
   assign first_s     = (beat_x_q == BX_W'(0)) && (line_y_q == LY_W'(0)) && (part_q == PT_W'(0));
   // an early subpart tlast also terminates the current output line
   assign in_entry_s  = {first_s, (eol_s | s_axis_tlast), s_axis_tdata};

   // Position counters and framing-error detection on each accepted beat
   always_comb begin
      beat_x_d    = beat_x_q;
      line_y_d    = line_y_q;
      part_d      = part_q;
      early_s     = 1'b0;
      missing_s   = 1'b0;
      frame_end_s = 1'b0;
      if (acc_s) begin
         if (eop_s || s_axis_tlast) begin
            // subpart ends here, either as expected or cut short by tlast
            early_s     = s_axis_tlast & ~eop_s;
            missing_s   = eop_s & ~s_axis_tlast;
            beat_x_d    = BX_W'(0);
            line_y_d    = LY_W'(0);
            part_d      = last_part_s ? PT_W'(0) : part_q + PT_W'(1);
            frame_end_s = last_part_s;
         end else if (eol_s) begin
            beat_x_d = BX_W'(0);
            line_y_d = line_y_q + LY_W'(1);
         end else begin
            beat_x_d = beat_x_q + BX_W'(1);
         end
      end else begin
         beat_x_d = beat_x_q;
      end
   end

   // Skid buffer: ent0 is the entry presented on m_axis, ent1 the overflow slot
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      case ({acc_s, pop_s})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               ent0_d = in_entry_s;
            end else begin
               ent1_d = in_entry_s;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = in_entry_s;
            end else begin
               ent0_d = ent1_q;
               ent1_d = in_entry_s;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   // Run-control state machine: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         STOPPED: begin
            if (enable) begin
               state_d = RUNNING;
            end else begin
               state_d = STOPPED;
            end
         end
         RUNNING: begin
            if (!enable) begin
               state_d = STOPPING;
            end else begin
               state_d = RUNNING;
            end
         end
         STOPPING: begin
            if (enable) begin
               state_d = RUNNING;
            end else if (frame_end_s) begin
               state_d = STOPPED;
            end else begin
               state_d = STOPPING;
            end
         end
         default: state_d = STOPPED;
      endcase
   end

   // Sticky error flags; a new error event takes priority over clearErrors
   always_comb begin
      err_early_d   = err_early_q;
      err_missing_d = err_missing_q;
      if (early_s) begin
         err_early_d = 1'b1;
      end else if (clearErrors) begin
         err_early_d = 1'b0;
      end else begin
         err_early_d = err_early_q;
      end
      if (missing_s) begin
         err_missing_d = 1'b1;
      end else if (clearErrors) begin
         err_missing_d = 1'b0;
      end else begin
         err_missing_d = err_missing_q;
      end
   end

   // State, counters, skid buffer and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= STOPPED;
         beat_x_q      <= BX_W'(0);
         line_y_q      <= LY_W'(0);
         part_q        <= PT_W'(0);
         ent0_q        <= EW'(0);
         ent1_q        <= EW'(0);
         cnt_q         <= 2'd0;
         tvalid_q      <= 1'b0;
         tready_q      <= 1'b0;
         frame_done_q  <= 1'b0;
         err_early_q   <= 1'b0;
         err_missing_q <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_x_q      <= beat_x_d;
         line_y_q      <= line_y_d;
         part_q        <= part_d;
         ent0_q        <= ent0_d;
         ent1_q        <= ent1_d;
         cnt_q         <= cnt_d;
         tvalid_q      <= (cnt_d != 2'd0);
         // ready is computed from next-cycle occupancy so it can be a flop
         tready_q      <= (state_d != STOPPED) && (cnt_d != 2'd2);
         frame_done_q  <= frame_end_s;
         err_early_q   <= err_early_d;
         err_missing_q <= err_missing_d;
         running_q     <= (state_d != STOPPED);
      end
   end

   assign s_axis_tready  = tready_q;
   assign m_axis_tvalid  = tvalid_q;
   assign m_axis_tuser   = ent0_q[EW-1];
   assign m_axis_tlast   = ent0_q[EW-2];
   assign m_axis_tdata   = ent0_q[STREAM_WIDTH-1:0];
   assign frameDone      = frame_done_q;
   assign errLastEarly   = err_early_q;
   assign errLastMissing = err_missing_q;
   assign running        = running_q;

endmodule

// File: tb/tb_framebuffer_stream_framer.sv
module tb_framebuffer_stream_framer;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        clearErrors;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [15:0] s_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        m_tuser;
   logic [15:0] m_tdata;
   logic        frameDone;
   logic        errLastEarly;
   logic        errLastMissing;
   logic        running;

   logic        tready_cmd;
   logic        toggle_en;
   logic        tog;

   int          vectors;
   int          miscompares;

   logic [15:0] od[$];
   logic        ol[$];
   logic        ou[$];
   int          fd_cnt;
   int          fd_at;
   int          occ;
   int          occ_max;
   logic        saw_full;

   framebuffer_stream_framer #(
      .X_RESOLUTION      (4),
      .Y_RESOLUTION      (4),
      .Y_LINE_RESOLUTION (2),
      .STREAM_WIDTH      (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .clearErrors    (clearErrors),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tready  (s_tready),
      .s_axis_tlast   (s_tlast),
      .s_axis_tdata   (s_tdata),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .m_axis_tlast   (m_tlast),
      .m_axis_tuser   (m_tuser),
      .m_axis_tdata   (m_tdata),
      .frameDone      (frameDone),
      .errLastEarly   (errLastEarly),
      .errLastMissing (errLastMissing),
      .running        (running)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign m_tready = toggle_en ? tog : tready_cmd;

   initial begin
      tog = 1'b0;
      forever begin
         @(posedge clk);
         #1 tog = ~tog;
      end
   end

   // output monitor: handshakes, frameDone position, buffer occupancy
   initial begin
      occ = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            occ = 0;
         end else begin
            if (s_tvalid && s_tready) occ++;
            if (m_tvalid && m_tready) begin
               occ--;
               od.push_back(m_tdata);
               ol.push_back(m_tlast);
               ou.push_back(m_tuser);
            end
         end
         if (occ > occ_max) occ_max = occ;
         if (enable && running && !s_tready) saw_full = 1'b1;
         if (frameDone) begin
            fd_cnt++;
            fd_at = od.size();
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      od.delete();
      ol.delete();
      ou.delete();
      fd_cnt   = 0;
      fd_at    = -1;
      occ_max  = 0;
      saw_full = 1'b0;
   endtask

   task automatic cycle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      int n;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         n++;
         if (n > 50) break;
      end
      if (n > 50) begin
         check("send_timeout", 32'(n), 32'd0);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int t;
      t = 0;
      while (od.size() < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         check("drain_timeout", 32'(od.size()), 32'(n));
      end
      cycle(2);
   endtask

   task automatic check_frame(input string pfx, input int n, input logic [15:0] base,
                              input logic [31:0] last_mask, input logic [31:0] user_mask);
      check({pfx, "_count"}, 32'(od.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_data%0d", pfx, i + 1), 32'(od[i]), 32'(base + 16'(i)));
         check($sformatf("%s_tlast%0d", pfx, i + 1), 32'(ol[i]), 32'(last_mask[i]));
         check($sformatf("%s_tuser%0d", pfx, i + 1), 32'(ou[i]), 32'(user_mask[i]));
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      enable      = 1'b0;
      clearErrors = 1'b0;
      s_tvalid    = 1'b0;
      s_tlast     = 1'b0;
      s_tdata     = 16'h0000;
      tready_cmd  = 1'b1;
      toggle_en   = 1'b0;
      clear_mon();
      cycle(3);

      // reset state
      check("rst_mvalid", 32'(m_tvalid), 32'd0);
      check("rst_mdata", 32'(m_tdata), 32'd0);
      check("rst_sready", 32'(s_tready), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_frameDone", 32'(frameDone), 32'd0);
      check("rst_errEarly", 32'(errLastEarly), 32'd0);
      check("rst_errMissing", 32'(errLastMissing), 32'd0);
      reset = 1'b0;
      cycle(2);
      check("stopped_sready", 32'(s_tready), 32'd0);

      // A: clean frame, tlast on beats 8 and 16, sink always ready
      clear_mon();
      enable = 1'b1;
      cycle(1);
      check("A_running", 32'(running), 32'd1);
      check("A_sready", 32'(s_tready), 32'd1);
      for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), (i == 7 || i == 15));
      wait_out(16);
      check_frame("A", 16, 16'h0100, 32'h0000_8888, 32'h0000_0001);
      check("A_fd_cnt", 32'(fd_cnt), 32'd1);
      check("A_fd_at", 32'(fd_at), 32'd16);
      check("A_errEarly", 32'(errLastEarly), 32'd0);
      check("A_errMissing", 32'(errLastMissing), 32'd0);

      // B: sink ready toggles every cycle
      clear_mon();
      toggle_en = 1'b1;
      for (int i = 0; i < 16; i++) send(16'h0200 + 16'(i), (i == 7 || i == 15));
      wait_out(16);
      toggle_en = 1'b0;
      check_frame("B", 16, 16'h0200, 32'h0000_8888, 32'h0000_0001);
      check("B_occ_le2", 32'(occ_max <= 2), 32'd1);
      check("B_saw_full", 32'(saw_full), 32'd1);
      check("B_fd_cnt", 32'(fd_cnt), 32'd1);

      // C: early tlast on beat 5, then part 1 of 8 beats
      clear_mon();
      for (int i = 0; i < 13; i++) send(16'h0300 + 16'(i), (i == 4 || i == 12));
      wait_out(13);
      check_frame("C", 13, 16'h0300, 32'h0000_1118, 32'h0000_0001);
      check("C_errEarly", 32'(errLastEarly), 32'd1);
      check("C_errMissing", 32'(errLastMissing), 32'd0);
      check("C_fd_cnt", 32'(fd_cnt), 32'd1);
      clearErrors = 1'b1;
      cycle(1);
      clearErrors = 1'b0;
      check("C_errEarly_cleared", 32'(errLastEarly), 32'd0);

      // D: tlast missing on beat 8, frame still ends at beat 16
      clear_mon();
      for (int i = 0; i < 16; i++) send(16'h0400 + 16'(i), (i == 15));
      wait_out(16);
      check_frame("D", 16, 16'h0400, 32'h0000_8888, 32'h0000_0001);
      check("D_errMissing", 32'(errLastMissing), 32'd1);
      check("D_errEarly", 32'(errLastEarly), 32'd0);
      check("D_fd_cnt", 32'(fd_cnt), 32'd1);
      check("D_fd_at", 32'(fd_at), 32'd16);
      clearErrors = 1'b1;
      cycle(1);
      clearErrors = 1'b0;
      check("D_errMissing_cleared", 32'(errLastMissing), 32'd0);

      // E: enable dropped after beat 3, run finishes the frame then stops
      clear_mon();
      for (int i = 0; i < 16; i++) begin
         send(16'h0500 + 16'(i), (i == 7 || i == 15));
         if (i == 2) enable = 1'b0;
         if (i == 14) begin
            check("E_running_mid", 32'(running), 32'd1);
            check("E_sready_mid", 32'(s_tready), 32'd1);
         end
      end
      check("E_sready_end", 32'(s_tready), 32'd0);
      check("E_running_end", 32'(running), 32'd0);
      wait_out(16);
      check_frame("E", 16, 16'h0500, 32'h0000_8888, 32'h0000_0001);
      check("E_fd_cnt", 32'(fd_cnt), 32'd1);

      // F: reset mid-frame with buffer full and sink stalled
      enable = 1'b1;
      cycle(2);
      clear_mon();
      for (int i = 0; i < 5; i++) send(16'h0600 + 16'(i), 1'b0);
      tready_cmd = 1'b0;
      send(16'h0605, 1'b0);
      check("F_sready_full", 32'(s_tready), 32'd0);
      check("F_mvalid_held", 32'(m_tvalid), 32'd1);
      check("F_mdata_held", 32'(m_tdata), 32'h0604);
      #3 reset = 1'b1;
      #1;
      check("F_rst_mvalid", 32'(m_tvalid), 32'd0);
      check("F_rst_mdata", 32'(m_tdata), 32'd0);
      check("F_rst_sready", 32'(s_tready), 32'd0);
      check("F_rst_running", 32'(running), 32'd0);
      check("F_rst_mtlast", 32'(m_tlast), 32'd0);
      check("F_rst_mtuser", 32'(m_tuser), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      clear_mon();
      tready_cmd = 1'b1;
      cycle(1);
      send(16'h0700, 1'b0);
      wait_out(1);
      check("F_first_data", 32'(od[0]), 32'h0700);
      check("F_first_tuser", 32'(ou[0]), 32'd1);
      check("F_outcount", 32'(od.size()), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/framebuffer_stream_framer.md
FRAMEBUFFER_STREAM_FRAMER -- requirements
Module: framebuffer_stream_framer

Interface
REQ-001 SHALL have parameter X_RESOLUTION, default 128: pixels per screen line.
REQ-002 SHALL have parameter Y_RESOLUTION, default 128: lines per full screen.
REQ-003 SHALL have parameter Y_LINE_RESOLUTION, default 128: lines per subpart; must divide Y_RESOLUTION.
REQ-004 SHALL have parameter STREAM_WIDTH, default 16: beat width, a multiple of 16 (RGB565 pixels); BPL = X_RESOLUTION*16/STREAM_WIDTH beats per line.
REQ-005 SHALL use one clock; reset is asynchronous and active-high: ports clk (in, 1) and reset (in, 1).
REQ-006 SHALL have enable (in, 1): run request.
REQ-007 SHALL have clearErrors (in, 1): clears sticky error flags.
REQ-008 SHALL have s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tlast (in, 1: end of subpart), s_axis_tdata (in, STREAM_WIDTH).
REQ-009 SHALL have m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tlast (out, 1: end of line), m_axis_tuser (out, 1: first beat of frame), m_axis_tdata (out, STREAM_WIDTH).
REQ-010 SHALL have frameDone (out, 1: one-cycle pulse), errLastEarly (out, 1: sticky), errLastMissing (out, 1: sticky), running (out, 1).

Function
REQ-011 SHALL implement states STOPPED, RUNNING, STOPPING.
REQ-012 Transitions: STOPPED->RUNNING when enable=1; RUNNING->STOPPING when enable=0; STOPPING->STOPPED after the last frame beat is accepted; STOPPING->RUNNING if enable returns to 1 before then.
REQ-013 s_axis_tready SHALL be 0 in STOPPED; otherwise it SHALL be 1 while the skid buffer holds fewer than 2 entries.
REQ-014 s_axis_tready SHALL be registered, with no combinational path from m_axis_tready.
REQ-015 SHALL use a 2-entry skid buffer: an accepted beat appears on m_axis 1 cycle later (minimum latency 1); full throughput is 1 beat per cycle when m_axis_tready=1.
REQ-016 m_axis_* SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-017 Counters beatX (0..BPL-1), lineY (0..Y_LINE_RESOLUTION-1) and part (0..Y_RESOLUTION/Y_LINE_RESOLUTION-1) SHALL advance only on input acceptance.
REQ-018 m_axis_tuser SHALL be 1 only on the beat with beatX=0, lineY=0, part=0.
REQ-019 m_axis_tlast SHALL be 1 on the beat with beatX=BPL-1.
REQ-020 Expected subpart end is beatX=BPL-1 with lineY=Y_LINE_RESOLUTION-1.
REQ-021 Early tlast (s_axis_tlast=1 before the expected subpart end): set errLastEarly; forward the beat with m_axis_tlast=1; reset beatX and lineY to 0; advance part.
REQ-022 Missing tlast (expected subpart end with s_axis_tlast=0): set errLastMissing; wrap the counters normally.
REQ-023 On acceptance of the final beat of the last part, part SHALL wrap to 0 and frameDone SHALL pulse on the same cycle as that beat's output (the following cycle).
REQ-024 When clearErrors and an error event coincide, the error event SHALL win.
REQ-025 running SHALL be 1 in RUNNING and in STOPPING.

Reset
REQ-026 Asynchronous reset SHALL force state STOPPED, counters 0, skid buffer empty, and all outputs 0, including m_axis_tdata.
REQ-027 Reset mid-frame SHALL discard buffered beats; the next accepted beat after restart is tagged tuser=1.

Verification
REQ-028 X=4, Y=4, YL=2, W=16, enable=1, tready=1, 16 beats with tlast on beats 8 and 16 -> tuser on beat 1 only; tlast on beats 4,8,12,16; frameDone once; no errors.
REQ-029 Same config, tready toggling 1/0 every cycle -> output data order and content identical to input; never more than 2 beats buffered; s_axis_tready drops when full.
REQ-030 tlast on beat 5 -> errLastEarly=1; beat 5 is output with m_axis_tlast=1; next beat starts part 1; clearErrors then clears the flag.
REQ-031 No tlast on beat 8 -> errLastMissing=1; beat 9 is treated as part 1, line 0.
REQ-032 enable dropped after beat 3 -> running stays 1 until beat 16 is accepted, then s_axis_tready=0 and running=0.
REQ-033 reset asserted mid-frame while tready=0 -> all outputs 0 immediately; after re-enable, the first output beat has tuser=1.
